// File: rtl/ddfs_pkg.sv
// -----------------------------------------------------------------------------
// ddfs_pkg
//  Shared definitions for the DDFS core: waveform select codes, slice widths
//  of the phase word, the offset-binary midpoint helper and an elaboration-time
//  sine helper used to fill the quarter-wave ROM.
// -----------------------------------------------------------------------------
package ddfs_pkg;

   // waveform select codes (cfg_wave)
   localparam logic [1:0] WAVE_SQR = 2'b00;
   localparam logic [1:0] WAVE_SIN = 2'b01;
   localparam logic [1:0] WAVE_TRI = 2'b10;
   localparam logic [1:0] WAVE_SAW = 2'b11;

   // quadrant = top two phase bits; wave select width
   localparam int QUAD_W = 2;
   localparam int WAVE_W = 2;

   typedef logic [WAVE_W-1:0] wave_t;

   // offset-binary midpoint M = 2**(data_w-1)
   function automatic int mid_code(input int data_w);
      return 1 << (data_w - 1);
   endfunction

   // Taylor series sine, only evaluated at elaboration for ROM contents.
   // On [0, pi/2] twelve terms leave an error far below one LSB.
   function automatic real sin_taylor(input real x);
      real term;
      real sum;
      term = x;
      sum  = x;
      for (int k = 1; k <= 12; k++) begin
         term = -term * x * x / (real'(2 * k) * real'(2 * k + 1));
         sum  = sum + term;
      end
      return sum;
   endfunction

endpackage

// File: rtl/ddfs_qlut.sv
// -----------------------------------------------------------------------------
// ddfs_qlut
//  Synchronous quarter-wave sine ROM, one cycle read latency.
//  lut[i] = round((2**(DATA_W-1)-1) * sin(pi/2 * (i+0.5) / 2**ADDR_W))
//  The half-LSB phase shift makes the quarter symmetric, so the mirrored
//  quadrants need no endpoint correction.
// Ports
//  clk    in   1          system clock
//  rd_en  in   1          read enable (the sample tick)
//  addr   in   ADDR_W     quarter-wave address
//  data   out  DATA_W-1   registered ROM word
// -----------------------------------------------------------------------------
module ddfs_qlut
   import ddfs_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 12
) (
   input  logic              clk,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-2:0] data
);

   localparam int  DEPTH = 2 ** ADDR_W;
   localparam real AMP   = real'((2 ** (DATA_W - 1)) - 1);
   localparam real HALF_PI = 3.14159265358979323846 / 2.0;

   function automatic logic [DATA_W-2:0] rom_entry(input int idx);
      real x;
      int  v;
      x = HALF_PI * (real'(idx) + 0.5) / real'(DEPTH);
      v = $rtoi(AMP * sin_taylor(x) + 0.5);
      return v[DATA_W-2:0];
   endfunction

   logic [DATA_W-2:0] rom [DEPTH];

   // each entry is a constant, so this elaborates to a plain ROM
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
      localparam logic [DATA_W-2:0] ROM_VAL = rom_entry(gi);
      assign rom[gi] = ROM_VAL;
   end

   always_ff @(posedge clk) begin
      if (rd_en) begin
         data <= rom[addr];
      end
   end

endmodule

// File: rtl/ddfs_gen.sv
// -----------------------------------------------------------------------------
// ddfs_gen
//  Parametrised direct digital frequency synthesiser. Phase accumulator plus
//  phase offset, quarter-wave sine ROM, sine/triangle/square/sawtooth select,
//  sample-rate divider and a valid/ready config port. New config is staged in
//  a shadow register and only made active on an accumulator wrap, so the
//  output never jumps mid-period. Output is unsigned offset-binary.
//  Parameter constraints: PHASE_W >= ADDR_W+2 and PHASE_W >= DATA_W+1.
// Ports
//  clk          in   1        system clock
//  rst          in   1        synchronous active-high reset
//  en           in   1        run enable; 0 freezes divider, accumulator, pipe
//  div          in   DIV_W    sample tick every div+1 clocks
//  cfg_valid    in   1        config offered
//  cfg_ready    out  1        shadow register free
//  cfg_fw       in   PHASE_W  frequency word
//  cfg_ph_off   in   PHASE_W  phase offset
//  cfg_wave     in   2        00 square, 01 sine, 10 triangle, 11 sawtooth
//  sample       out  DATA_W   output sample
//  sample_valid out  1        pulse when sample updates
//  wrap         out  1        pulse after the tick on which acc overflowed
// -----------------------------------------------------------------------------
module ddfs_gen
   import ddfs_pkg::*;
#(
   parameter int PHASE_W = 24,
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 12,
   parameter int DIV_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [DIV_W-1:0]   div,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [PHASE_W-1:0] cfg_fw,
   input  logic [PHASE_W-1:0] cfg_ph_off,
   input  logic [1:0]         cfg_wave,
   output logic [DATA_W-1:0]  sample,
   output logic               sample_valid,
   output logic               wrap
);

   localparam int P_W = DATA_W + 1;   // phase bits carried for tri/saw
   localparam logic [DATA_W-1:0] MID     = DATA_W'(mid_code(DATA_W));
   localparam logic [DATA_W-1:0] MID_M1  = MID - DATA_W'(1);
   localparam logic [DIV_W-1:0]  CNT_ONE = DIV_W'(1);

   typedef struct packed {
      logic [PHASE_W-1:0] fw;
      logic [PHASE_W-1:0] ph_off;
      wave_t              wave;
   } cfg_t;

   cfg_t cfg_act;
   cfg_t cfg_sh;
   logic cfg_pend;     // shadow holds a config not yet applied
   logic cfg_force;    // shadow was loaded while stopped: apply without a wrap
   logic rdy_pend;     // re-open cfg_ready one cycle after the apply

   logic [DIV_W-1:0]   cnt;
   logic [PHASE_W-1:0] acc;

   logic               tick;
   logic               hs;
   logic               carry;
   logic [PHASE_W:0]   acc_sum;
   logic [PHASE_W-1:0] ph;
   logic [QUAD_W-1:0]  ph_quad;
   logic [ADDR_W-1:0]  ph_addr;
   logic               unused_ph_bits;

   // pipeline stage registers
   logic               s1_v;
   logic               s1_half;
   wave_t              s1_wave;
   logic [P_W-1:0]     s1_p;
   logic [ADDR_W-1:0]  s1_addr;
   logic               s2_v;
   logic               s2_half;
   wave_t              s2_wave;
   logic [P_W-1:0]     s2_p;
   logic [DATA_W-2:0]  lut_q;
   logic [DATA_W-1:0]  lut_ext;
   logic [DATA_W-1:0]  wave_val;

   assign tick    = en && (cnt == div);
   assign hs      = cfg_valid && cfg_ready;
   assign acc_sum = {1'b0, acc} + {1'b0, cfg_act.fw};
   assign carry   = tick && acc_sum[PHASE_W];

   assign ph      = acc + cfg_act.ph_off;
   assign ph_quad = ph[PHASE_W-1 -: QUAD_W];
   assign ph_addr = ph[PHASE_W-3 -: ADDR_W];
   // low phase bits below both the ROM address and the tri/saw slice
   assign unused_ph_bits = ^ph;

   // ---------------------------------------------------------------------
   // sample-rate divider and phase accumulator
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         acc  <= '0;
         wrap <= 1'b0;
      end else begin
         wrap <= carry;
         if (tick) begin
            cnt <= '0;
            acc <= acc_sum[PHASE_W-1:0];
         end else if (en) begin
            cnt <= cnt + CNT_ONE;
         end
      end
   end

   // ---------------------------------------------------------------------
   // config handshake, shadow and active registers
   //  A handshake in the same cycle as a wrap cannot apply on that wrap:
   //  cfg_pend is still low then, so it waits for the next one.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_act   <= '0;
         cfg_sh    <= '0;
         cfg_ready <= 1'b1;
         cfg_pend  <= 1'b0;
         cfg_force <= 1'b0;
         rdy_pend  <= 1'b0;
      end else begin
         rdy_pend <= 1'b0;
         if (rdy_pend) begin
            cfg_ready <= 1'b1;
         end
         if (hs) begin
            cfg_sh    <= {cfg_fw, cfg_ph_off, cfg_wave};
            cfg_ready <= 1'b0;
            cfg_pend  <= 1'b1;
            cfg_force <= !en;
         end else if (cfg_pend && (cfg_force || carry)) begin
            cfg_act   <= cfg_sh;
            cfg_pend  <= 1'b0;
            cfg_force <= 1'b0;
            rdy_pend  <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // S2 ROM read; address is folded in S1 so only the half bit travels
   // ---------------------------------------------------------------------
   ddfs_qlut #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_qlut (
      .clk   (clk),
      .rd_en (tick),
      .addr  (s1_addr),
      .data  (lut_q)
   );

   assign lut_ext = {1'b0, lut_q};

   // S3 waveform mapping
   always_comb begin
      wave_val = MID;
      case (s2_wave)
         WAVE_SQR: wave_val = s2_half ? '0 : '1;
         WAVE_SIN: wave_val = s2_half ? (MID_M1 - lut_ext) : (MID + lut_ext);
         WAVE_TRI: wave_val = s2_p[DATA_W] ? ~s2_p[DATA_W-1:0] : s2_p[DATA_W-1:0];
         WAVE_SAW: wave_val = s2_p[DATA_W:1];
      endcase
   end

   // ---------------------------------------------------------------------
   // pipeline, advances on tick only
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v         <= 1'b0;
         s1_half      <= 1'b0;
         s1_wave      <= '0;
         s1_p         <= '0;
         s1_addr      <= '0;
         s2_v         <= 1'b0;
         s2_half      <= 1'b0;
         s2_wave      <= '0;
         s2_p         <= '0;
         sample       <= MID;
         sample_valid <= 1'b0;
      end else begin
         sample_valid <= tick && s2_v;
         if (tick) begin
            s1_v    <= 1'b1;
            s1_half <= ph_quad[1];
            s1_wave <= cfg_act.wave;
            s1_p    <= ph[PHASE_W-1 -: P_W];
            // odd quadrants run the quarter table backwards
            s1_addr <= ph_quad[0] ? ~ph_addr : ph_addr;
            s2_v    <= s1_v;
            s2_half <= s1_half;
            s2_wave <= s1_wave;
            s2_p    <= s1_p;
            if (s2_v) begin
               sample <= wave_val;
            end
         end
      end
   end

endmodule
